// File: rtl/div_seq_32.sv
// div_seq_32 -- multi-cycle radix-2 restoring integer divider.
//
// Produces one quotient bit per clock. Signed operands are reduced to
// magnitudes on capture and the signs are reapplied in a single fix-up
// cycle, giving truncating division (remainder takes the dividend's sign).
// Divide-by-zero and the signed -2^(W-1)/-1 overflow bypass the iteration
// and complete in one cycle.
//
// Ports:
//   clk    in   1  rising-edge clock
//   rst    in   1  synchronous active-high reset (aborts any operation)
//   start  in   1  request a division; accepted only when busy=0
//   sgn    in   1  1 = two's-complement operands, 0 = unsigned
//   a      in   W  dividend
//   b      in   W  divisor
//   busy   out  1  high while iterating or fixing up
//   done   out  1  one-cycle pulse, q0/q1/st valid
//   q0     out  W  quotient
//   q1     out  W  remainder
//   st     out  4  {N, Z, C, V}
module div_seq_32 #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         sgn,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] q0,
  output logic [W-1:0] q1,
  output logic [3:0]   st
);

  localparam int CW = $clog2(W) + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_DIV  = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [W-1:0] MIN_NEG = {1'b1, {(W-1){1'b0}}};

  // Two's-complement negate when en is set, pass-through otherwise.
  function automatic logic [W-1:0] neg_if(input logic [W-1:0] x, input logic en);
    logic signed [W-1:0] xs;
    xs = x;
    return en ? W'(-xs) : x;
  endfunction

  logic [1:0]    state;
  logic [CW-1:0] cnt;

  // Working registers: partial remainder, quotient/dividend shifter, divisor.
  logic [W-1:0]  rem;
  logic [W-1:0]  quo;
  logic [W-1:0]  dvs;
  logic          neg_q;
  logic          neg_r;
  logic          sgn_r;

  logic          accept;
  logic          div0;
  logic          ovf;
  logic [W-1:0]  a_mag;
  logic [W-1:0]  b_mag;
  logic [W:0]    rp;
  logic [W+1:0]  diff;
  logic          ge;
  logic          last;
  logic [W-1:0]  qv;
  logic [W-1:0]  rv;

  assign busy   = (state == S_DIV) || (state == S_FIX);
  assign done   = (state == S_DONE);
  assign accept = start && ((state == S_IDLE) || (state == S_DONE));

  assign div0  = (b == '0);
  assign ovf   = sgn && (a == MIN_NEG) && (b == '1);
  assign a_mag = neg_if(a, sgn & a[W-1]);
  assign b_mag = neg_if(b, sgn & b[W-1]);

  // Shift the next dividend bit into the remainder and trial-subtract.
  // The extra top bit of diff is the borrow: clear means R' >= B.
  assign rp   = {rem, quo[W-1]};
  assign diff = {1'b0, rp} - {2'b00, dvs};
  assign ge   = ~diff[W+1];
  assign last = (cnt == CW'(W - 1));

  assign qv = neg_if(quo, neg_q);
  assign rv = neg_if(rem, neg_r);

  // Control and architectural result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= '0;
      q0    <= '0;
      q1    <= '0;
      st    <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (accept) begin
            if (div0) begin
              q0    <= '1;
              q1    <= a;
              st    <= {sgn, 1'b0, (a != '0), 1'b1};
              state <= S_DONE;
            end else if (ovf) begin
              q0    <= MIN_NEG;
              q1    <= '0;
              st    <= 4'b1001;
              state <= S_DONE;
            end else begin
              cnt   <= '0;
              state <= S_DIV;
            end
          end else begin
            state <= S_IDLE;
          end
        end
        S_DIV: begin
          cnt <= cnt + 1'b1;
          if (last) state <= S_FIX;
        end
        S_FIX: begin
          q0    <= qv;
          q1    <= rv;
          st    <= {sgn_r & qv[W-1], (qv == '0), (rv != '0), 1'b0};
          state <= S_DONE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Datapath: loaded on accept, iterated in DIV; state gating keeps it inert otherwise.
  always_ff @(posedge clk) begin
    if (accept) begin
      quo   <= a_mag;
      dvs   <= b_mag;
      rem   <= '0;
      sgn_r <= sgn;
      neg_q <= sgn & (a[W-1] ^ b[W-1]);
      neg_r <= sgn & a[W-1];
    end else if (state == S_DIV) begin
      rem <= ge ? diff[W-1:0] : rp[W-1:0];
      quo <= {quo[W-2:0], ge};
    end
  end

endmodule

// File: tb/tb_div_seq_32.sv
// Scoreboard bench for div_seq_32: directed operations push their expected
// quotient, remainder, status and completion cycle; a monitor pops and
// compares every time done is seen.
module tb_div_seq_32;

  logic        clk;
  logic        rst;
  logic        start;
  logic        sgn;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] q0;
  logic [31:0] q1;
  logic [3:0]  st;

  int checks;
  int errors;
  int cyc;
  int busy_cnt;

  typedef struct {
    logic [31:0] q0;
    logic [31:0] q1;
    logic [3:0]  st;
    int          cyc;
  } exp_t;

  exp_t sb[$];

  div_seq_32 #(.W(32)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .sgn   (sgn),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .q0    (q0),
    .q1    (q1),
    .st    (st)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) if (busy) busy_cnt <= busy_cnt + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%08h required=0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (done) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done actual=1 required=0 (t=%0t)", $time);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("q0", q0, e.q0);
        chk("q1", q1, e.q1);
        chk("st", {28'b0, st}, {28'b0, e.st});
        chk("done_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  // Drive a request at the current negedge and push its expectation.
  // A full-path result shows up 34 counter ticks later, a fast-path one 1 later.
  task automatic drive(input logic [31:0] ta, input logic [31:0] tb_v, input logic ts,
                       input logic [31:0] e0, input logic [31:0] e1, input logic [3:0] es,
                       input bit fast);
    exp_t e;
    start = 1'b1;
    a     = ta;
    b     = tb_v;
    sgn   = ts;
    e.q0  = e0;
    e.q1  = e1;
    e.st  = es;
    e.cyc = cyc + (fast ? 1 : 34);
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic issue(input logic [31:0] ta, input logic [31:0] tb_v, input logic ts,
                       input logic [31:0] e0, input logic [31:0] e1, input logic [3:0] es,
                       input bit fast);
    @(negedge clk);
    drive(ta, tb_v, ts, e0, e1, es, fast);
  endtask

  task automatic wait_empty();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 80; i++) begin
      if (sb.size() == 0) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL timeout pending=%0d required=0", sb.size());
      sb.delete();
    end
  endtask

  initial begin
    bit seen;
    clk      = 1'b0;
    cyc      = 0;
    busy_cnt = 0;
    checks   = 0;
    errors   = 0;
    // Reset with start held high: reset must win.
    rst   = 1'b1;
    start = 1'b1;
    a     = 32'd100;
    b     = 32'd7;
    sgn   = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_q0", q0, 32'd0);
    chk("rst_q1", q1, 32'd0);
    chk("rst_st", {28'b0, st}, 32'd0);
    start = 1'b0;
    rst   = 1'b0;

    // 100/7 unsigned, with busy duration.
    @(negedge clk);
    busy_cnt = 0;
    drive(32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 4'b0010, 1'b0);
    wait_empty();
    chk("busy_cycles", 32'(busy_cnt), 32'd33);

    issue(32'hFFFFFFF9, 32'd2, 1'b1, 32'hFFFFFFFD, 32'hFFFFFFFF, 4'b1010, 1'b0);
    wait_empty();
    issue(32'd7, 32'hFFFFFFFE, 1'b1, 32'hFFFFFFFD, 32'd1, 4'b1010, 1'b0);
    wait_empty();
    issue(32'h1234, 32'd0, 1'b0, 32'hFFFFFFFF, 32'h1234, 4'b0011, 1'b1);
    wait_empty();
    issue(32'hFFFFFFF0, 32'd0, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFF0, 4'b1011, 1'b1);
    wait_empty();
    issue(32'h80000000, 32'hFFFFFFFF, 1'b1, 32'h80000000, 32'd0, 4'b1001, 1'b1);
    wait_empty();
    issue(32'h80000000, 32'hFFFFFFFF, 1'b0, 32'd0, 32'h80000000, 4'b0110, 1'b0);
    wait_empty();
    issue(32'd0, 32'd5, 1'b1, 32'd0, 32'd0, 4'b0100, 1'b0);
    wait_empty();

    // Start while busy is ignored.
    issue(32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 4'b0010, 1'b0);
    repeat (8) @(negedge clk);
    start = 1'b1;
    a     = 32'd50;
    b     = 32'd3;
    sgn   = 1'b1;
    chk("busy_midop", {31'b0, busy}, 32'd1);
    @(negedge clk);
    start = 1'b0;
    wait_empty();

    // Back-to-back: second start issued in the DONE cycle of the first.
    issue(32'd1000, 32'd10, 1'b0, 32'd100, 32'd0, 4'b0000, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    chk("b2b_done_seen", {31'b0, seen}, 32'd1);
    if (seen) drive(32'd7, 32'd2, 1'b0, 32'd3, 32'd1, 4'b0010, 1'b0);
    wait_empty();

    // Reset mid-operation aborts without a done pulse.
    issue(32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 4'b0010, 1'b0);
    repeat (13) @(negedge clk);
    rst = 1'b1;
    sb.delete();
    @(negedge clk);
    chk("abort_busy", {31'b0, busy}, 32'd0);
    chk("abort_q0", q0, 32'd0);
    chk("abort_q1", q1, 32'd0);
    chk("abort_st", {28'b0, st}, 32'd0);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    issue(32'hFFFFFFFF, 32'h10, 1'b0, 32'h0FFFFFFF, 32'hF, 4'b0010, 1'b0);
    wait_empty();
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/div_seq_32.md
Name: div_seq_32

Overview:
- Multi-cycle 32-bit integer divider. It is the inverse companion of the combinational multiplier in the ALU.
- Produces the quotient on q0 and the remainder on q1, and a 4-bit status word in the same bit order as the ALU: bit0 V, bit1 C, bit2 Z, bit3 N.
- Sits beside the ALU in the execute stage. The controller stalls on busy and samples the results on done.
- Radix-2 restoring algorithm, one quotient bit per clock.

Parameters:
- W, 32, operand/result width; must be >= 2; the counter is sized ceil(log2(W))+1.

Ports:
- clk  input  1  clock, all state updates on the rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  request a division; sampled only when busy=0
- sgn  input  1  1 = signed (two's complement), 0 = unsigned; captured with start
- a  input  W  dividend; captured with start
- b  input  W  divisor; captured with start
- busy  output  1  high while an operation is in progress (states DIV, FIX)
- done  output  1  single-cycle pulse; q0/q1/st are valid in that cycle
- q0  output  W  quotient
- q1  output  W  remainder
- st  output  4  {N, Z, C, V}

Behaviour:
- Reset (synchronous):
  - state=IDLE; busy=0, done=0, q0=0, q1=0, st=0; counter=0.
  - Reset wins over start in the same cycle.
  - Reset mid-operation aborts; no done pulse is produced.
- States: IDLE, DIV, FIX, DONE. busy=1 in DIV and FIX only. done=1 only in DONE.
- IDLE or DONE with start=1:
  - Capture a, b and sgn.
  - Compute |a| and |b| when sgn=1; otherwise use a and b unchanged.
  - Record neg_q = sgn & (a[W-1]^b[W-1]) and neg_r = sgn & a[W-1].
  - If b==0, or (sgn & a==100..0 & b==all-ones): take the fast path and go directly to DONE.
  - Otherwise clear the partial remainder, set counter=0 and go to DIV.
- Start with busy=0 is accepted in DONE as well, so back-to-back operations run with no idle gap.
- start while busy=1 is ignored. It is not queued and the operands are not recaptured.
- DIV, one iteration per cycle:
  - Form R' = {R[W-1:0], Q[W-1]} (W+1 bits) and trial = R' - B.
  - If trial >= 0: R = trial and shift 1 into Q. Otherwise R = R' and shift 0 into Q.
  - Q shifts left; the dividend bits feed in MSB first.
  - After W iterations (counter==W-1 on the last), go to FIX.
- FIX:
  - q0 = neg_q ? -Q : Q.
  - q1 = neg_r ? -R : R. The remainder takes the sign of the dividend (truncating division).
  - Compute st, then go to DONE.
- DONE:
  - done=1 for exactly one cycle. Next state is IDLE, or DIV / DONE if start is accepted.
- q0, q1 and st hold their values until the next operation's FIX or fast path overwrites them. They do not clear on returning to IDLE.
- Latency: start sampled on edge E0; done is high in the cycle after edge E(W+1), i.e. W+1 cycles later (33 for W=32). The fast path gives done after 1 cycle.
- Status:
  - N = sgn & q0[W-1].
  - Z = (q0==0).
  - C = (q1!=0), meaning the division was inexact.
  - V = divide-by-zero or signed overflow.
- Divide by zero: q0=all-ones, q1=a (unmodified), V=1, C=(a!=0), Z=0, N=sgn.
- Signed overflow (-2^(W-1) / -1): q0=100..0, q1=0, V=1, N=1, Z=0, C=0.
- Unsigned mode never sets V except on divide-by-zero.
- Edge case: a=0 with a nonzero divisor goes through the full DIV path and gives q0=0, q1=0, Z=1, C=0.

Test Plan:
- Unsigned 100/7, sgn=0 -> after 33 cycles done=1, q0=14, q1=2, st=4'b0010 (C=1), busy high for exactly 32 cycles... plus FIX, 33 total.
- Signed -7/2 (a=0xFFFFFFF9, b=2, sgn=1) -> q0=0xFFFFFFFD, q1=0xFFFFFFFF, st=4'b1010. Also 7/-2 -> q0=0xFFFFFFFD, q1=1.
- Divide by zero, a=0x1234, b=0, sgn=0 -> done one cycle after start, q0=0xFFFFFFFF, q1=0x1234, st=4'b0011.
- Signed overflow, a=0x80000000, b=0xFFFFFFFF, sgn=1 -> fast path, q0=0x80000000, q1=0, st=4'b1001. The same operands with sgn=0 -> full path, q0=0, q1=0x80000000, st=4'b0110.
- Start pulsed with new operands at cycle 10 of 100/7 -> ignored, and the first result (14, 2) is unchanged. Start asserted during the DONE cycle -> second operation accepted, its done 33 cycles later.
- rst asserted at cycle 15 of an operation -> next cycle busy=0, q0=q1=0, st=0, and no done pulse ever appears. A subsequent start of 0xFFFFFFFF/0x10 unsigned -> q0=0x0FFFFFFF, q1=0xF, st=4'b0010.
